// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/subtract unit. WIDTH bits are split into STAGES slices with one
// slice added per stage and the carry registered between stages. Valid/ready on both sides.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SL = WIDTH / STAGES;

    if ((WIDTH < 2) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    function automatic logic [SL:0] add_slice(input logic [SL-1:0] x, input logic [SL-1:0] y,
                                              input logic ci);
        logic [SL-1:0] s;
        logic          c;
        s = {SL{1'b0}};
        c = ci;
        for (int i = 0; i < SL; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (y[i] & c) | (c & x[i]);
        end
        return {c, s};
    endfunction

    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];
    logic             r_ovf;
    logic             r_zero;
    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;

    assign w_adv   = out_ready | ~r_vld[STAGES-1];
    assign w_b_eff = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic             w_vld_in;
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_s_in;
        logic             w_c_in;
        logic [SL:0]      w_res;
        logic [WIDTH-1:0] w_s_nxt;

        if (k == 0) begin : g_src
            assign w_vld_in = in_valid;
            assign w_a_in   = a;
            assign w_b_in   = w_b_eff;
            assign w_s_in   = {WIDTH{1'b0}};
            assign w_c_in   = sub ? 1'b1 : cin;
        end else begin : g_src
            assign w_vld_in = r_vld[k-1];
            assign w_a_in   = r_a[k-1];
            assign w_b_in   = r_b[k-1];
            assign w_s_in   = r_s[k-1];
            assign w_c_in   = r_c[k-1];
        end

        assign w_res = add_slice(w_a_in[k*SL +: SL], w_b_in[k*SL +: SL], w_c_in);

        // Splice this stage's finished slice into the partial sum riding down the pipe
        always_comb begin
            w_s_nxt             = w_s_in;
            w_s_nxt[k*SL +: SL] = w_res[SL-1:0];
        end

        // Stage register: the whole pipe shifts together on advance and holds otherwise
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= {WIDTH{1'b0}};
                r_b[k]   <= {WIDTH{1'b0}};
                r_s[k]   <= {WIDTH{1'b0}};
                r_c[k]   <= 1'b0;
            end else if (w_adv) begin
                r_vld[k] <= w_vld_in;
                r_a[k]   <= w_a_in;
                r_b[k]   <= w_b_in;
                r_s[k]   <= w_s_nxt;
                r_c[k]   <= w_res[SL];
            end
        end

        if (k == STAGES - 1) begin : g_flags
            logic w_c_msb;
            // Carry into the MSB recovered from its sum bit: s = x ^ y ^ c
            assign w_c_msb = w_a_in[WIDTH-1] ^ w_b_in[WIDTH-1] ^ w_res[SL-1];

            // Result flags registered together with the final slice
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv) begin
                    r_ovf  <= w_c_msb ^ w_res[SL];
                    r_zero <= (w_s_nxt == {WIDTH{1'b0}});
                end
            end
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and randomised checks of pipelined_adder: latency, arithmetic flags, stall, reset,
// plus a latency sweep over STAGES = 1, 2 and 16.
module tb_pipelined_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, out_ready, cin, sub, sw_valid;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, cout, ovf, zero;
    logic [W-1:0] sum;
    logic         s1_rdy, s1_vld, s1_co, s1_ov, s1_z;
    logic         s2_rdy, s2_vld, s2_co, s2_ov, s2_z;
    logic         s16_rdy, s16_vld, s16_co, s16_ov, s16_z;
    logic [W-1:0] s1_sum, s2_sum, s16_sum;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero));
    pipelined_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_rdy), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(s1_vld), .out_ready(1'b1), .sum(s1_sum),
        .cout(s1_co), .ovf(s1_ov), .zero(s1_z));
    pipelined_adder #(.WIDTH(W), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s2_rdy), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(s2_vld), .out_ready(1'b1), .sum(s2_sum),
        .cout(s2_co), .ovf(s2_ov), .zero(s2_z));
    pipelined_adder #(.WIDTH(W), .STAGES(16)) u_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s16_rdy), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(s16_vld), .out_ready(1'b1), .sum(s16_sum),
        .cout(s16_co), .ovf(s16_ov), .zero(s16_z));

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkr(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed {co,ov,z,sum}=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: {cout, ovf, zero, sum}
    function automatic logic [18:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic s);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         co, v;
        if (s) begin
            r  = x - y;
            co = (x >= y);
            v  = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            t  = {1'b0, x} + {1'b0, y} + {16'h0000, ci};
            r  = t[W-1:0];
            co = t[W];
            v  = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {co, v, (r == 16'h0000), r};
    endfunction

    task automatic one_shot(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic s, input logic [W-1:0] es,
                            input logic eco, input logic eov, input logic ez);
        int n;
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0; a = ~x; b = ~y; cin = ~ci; sub = ~s;
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chkn({tag, "_latency"}, n, 4);
        chk16({tag, "_sum"}, sum, es);
        chk1({tag, "_cout"}, cout, eco);
        chk1({tag, "_ovf"}, ovf, eov);
        chk1({tag, "_zero"}, zero, ez);
        tick();
        chk1({tag, "_drained"}, out_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] q [$];
        logic [18:0] hold_val, expv;
        logic [W-1:0] e;
        logic hold_v, accepted;
        int sent, got, cyc, l1, l2, l16;
        logic [W-1:0] m1, m2, m16;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sw_valid = 1'b0;
        a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        chk1("rst_out_valid", out_valid, 1'b0);
        chk16("rst_sum", sum, 16'h0000);
        chkr("rst_flags", {cout, ovf, zero, sum}, 19'h00000);
        chk1("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        one_shot("t1_add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        one_shot("t1_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
        one_shot("t2_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        one_shot("t2_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        one_shot("t3_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        one_shot("t3_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        one_shot("t3_cin_ign", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0, 1'b0);

        // Fill the pipe with out_ready low, then hold a fifth op against the stall
        out_ready = 1'b0; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a = 16'(i) << 8; b = 16'(i);
            tick();
        end
        a = 16'hDEAD; b = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            chk1("t5_in_ready_stall", in_ready, 1'b0);
            chk16("t5_sum_stall", sum, 16'h0101);
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            e = (16'(i) << 8) | 16'(i);
            chk1("t5_drain_valid", out_valid, 1'b1);
            chk16("t5_drain_sum", sum, e);
            tick();
        end
        chk1("t5_no_extra", out_valid, 1'b0);

        // Back-to-back random traffic against a scoreboard with random backpressure
        sent = 0; got = 0; cyc = 0; hold_v = 1'b0; hold_val = 19'h00000;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1));
        while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            if (hold_v) begin
                chk1("t4_stall_valid", out_valid, 1'b1);
                chkr("t4_stall_data", {cout, ovf, zero, sum}, hold_val);
            end
            if (out_valid && out_ready) begin
                got++;
                if (q.size() == 0) begin
                    chk1("t4_extra_result", out_valid, 1'b0);
                end else begin
                    expv = q.pop_front();
                    chkr("t4_result", {cout, ovf, zero, sum}, expv);
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_val = {cout, ovf, zero, sum};
            accepted = in_valid && in_ready;
            if (accepted) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            tick();
            cyc++;
            if (sent < 100) begin
                a = 16'($urandom); b = 16'($urandom);
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        chkn("t4_sent", sent, 100);
        chkn("t4_received", got, 100);

        // Async reset with ops in flight, then confirm nothing stale emerges
        out_ready = 1'b1; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            a = 16'(i) << 4; b = 16'h0001;
            tick();
        end
        chk1("t6_pre_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk1("t6_async_valid", out_valid, 1'b0);
        chk16("t6_async_sum", sum, 16'h0000);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1("t6_no_stale", out_valid, 1'b0);
        end
        one_shot("t6_after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

        // STAGES sweep: latency must equal the stage count
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; sw_valid = 1'b1;
        l1 = 0; l2 = 0; l16 = 0; m1 = 16'h0000; m2 = 16'h0000; m16 = 16'h0000;
        tick();
        sw_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (s1_vld && l1 == 0) begin l1 = n; m1 = s1_sum; end
            if (s2_vld && l2 == 0) begin l2 = n; m2 = s2_sum; end
            if (s16_vld && l16 == 0) begin l16 = n; m16 = s16_sum; end
            tick();
        end
        chkn("sweep_s1_latency", l1, 1);
        chkn("sweep_s2_latency", l2, 2);
        chkn("sweep_s16_latency", l16, 16);
        chk16("sweep_s1_sum", m1, 16'h5555);
        chk16("sweep_s2_sum", m2, 16'h5555);
        chk16("sweep_s16_sum", m16, 16'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
